// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART transmitter definitions: FSM state encoding, default frame
// constants and a counter-width helper.
package fifo_uart_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } state_e;

    localparam int unsigned DefDbit = 8;
    localparam int unsigned DefCpb  = 16;

    // Width of a counter covering 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO-side and serial-side signals of the UART transmitter.
interface fifo_uart_tx_if
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned DBIT = DefDbit
) ();

    logic            tx_en;
    logic            fifo_empty;
    logic [DBIT-1:0] fifo_rdata;
    logic            fifo_rd;
    logic            tx;
    logic            busy;

    modport master (
        output tx_en,
        output fifo_empty,
        output fifo_rdata,
        input  fifo_rd,
        input  tx,
        input  busy
    );

    modport slave (
        input  tx_en,
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_rd,
        output tx,
        output busy
    );

endinterface

// File: rtl/bit_timer.sv
// Per-bit cycle counter: counts 0..CPB-1, wraps on each bit boundary and
// flags the last cycle of a bit with tick.
module bit_timer
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CPB = DefCpb
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = cnt_width(CPB);
    localparam logic [CW-1:0] Last = CW'(CPB - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == Last)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == Last);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a synchronous FIFO: pops one word per frame and
// sends start bit, DBIT data bits LSB first, and a stop bit.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned DBIT = DefDbit,
    parameter int unsigned CPB  = DefCpb
) (
    input logic           clk,
    input logic           reset,
    fifo_uart_tx_if.slave bus
);

    localparam int unsigned IW = cnt_width(DBIT);
    localparam logic [IW-1:0] LastBit = IW'(DBIT - 1);

    state_e          state_q;
    logic [DBIT-1:0] shreg_q;
    logic [IW-1:0]   idx_q;
    logic            tx_q;
    logic            busy_q;
    logic            start;
    logic            timer_clear;
    logic            tick;

    // The pop strobe is combinational so the FIFO advances on the same edge
    // that captures its head word; reset masks it.
    assign start       = (state_q == StIdle) && bus.tx_en && !bus.fifo_empty && !reset;
    assign timer_clear = (state_q == StIdle);

    assign bus.fifo_rd = start;
    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;

    bit_timer #(
        .CPB (CPB)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        shreg_q <= bus.fifo_rdata;
                        idx_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (tick) begin
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (tick) begin
                        if (idx_q == LastBit) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            tx_q    <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx (DBIT=8, CPB=4): table-driven frames,
// hand-written corner sequences and a frame-level reference model.
module tb_fifo_uart_tx;

    localparam int unsigned DBIT  = 8;
    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = (DBIT + 2) * CPB;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [9:0] bits;  // bit i is the i-th symbol on the line
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fifo_uart_tx_if #(.DBIT(DBIT)) bus ();

    fifo_uart_tx #(
        .DBIT (DBIT),
        .CPB  (CPB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_total = 0;
    logic [7:0] q[$];
    logic rd_seen = 1'b0;

    // Frame-level reference model state.
    int m_left = 0;
    int m_pos = 0;
    logic [9:0] m_bits = '1;
    logic m_tx, m_busy, m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        bus.fifo_empty = (q.size() == 0);
        bus.fifo_rdata = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] d);
        q.push_back(d);
        refresh();
    endtask

    // Advance one cycle; the FIFO model pops if the DUT strobed in the last cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rd_seen && q.size() > 0) void'(q.pop_front());
        refresh();
        #1;
    endtask

    always @(negedge clk) begin
        rd_seen = bus.fifo_rd;
        if (bus.fifo_rd) rd_total++;
        if (reset) begin
            m_left = 0;
            m_tx = 1'b1;
            m_busy = 1'b0;
            m_rd = 1'b0;
        end else if (m_left == 0) begin
            m_tx = 1'b1;
            m_busy = 1'b0;
            m_rd = bus.tx_en && !bus.fifo_empty;
            if (m_rd) begin
                m_bits = {1'b1, bus.fifo_rdata, 1'b0};
                m_left = FRAME;
                m_pos = 0;
            end
        end else begin
            m_tx = m_bits[m_pos / CPB];
            m_busy = 1'b1;
            m_rd = 1'b0;
            m_pos++;
            m_left--;
        end
        check("model {tx,busy,rd}", {29'd0, bus.tx, bus.busy, bus.fifo_rd},
              {29'd0, m_tx, m_busy, m_rd});
    end

    task automatic wait_rd(input string name, input int limit);
        int n = 0;
        while (!bus.fifo_rd && n < limit) begin
            tick();
            n++;
        end
        check({name, " rd seen"}, {31'd0, bus.fifo_rd}, 32'd1);
    endtask

    // Expects fifo_rd in the current cycle (or soon); captures the frame mid-bit.
    task automatic run_frame(input string name, input logic [9:0] exp_bits, input int drop_at);
        logic [9:0] got = '0;
        int busy_n = 0;
        int rd_n = 1;
        wait_rd(name, 20);
        for (int i = 0; i < int'(FRAME); i++) begin
            tick();
            if (i == drop_at) bus.tx_en = 1'b0;
            if (i % CPB == CPB / 2) got[i / CPB] = bus.tx;
            if (bus.busy) busy_n++;
            if (bus.fifo_rd) rd_n++;
        end
        check({name, " bits"}, {22'd0, got}, {22'd0, exp_bits});
        check({name, " busy cycles"}, busy_n, FRAME);
        check({name, " rd pulses"}, rd_n, 1);
        tick();
        check({name, " idle after"}, {30'd0, bus.tx, bus.busy}, 32'd2);
    endtask

    vec_t tab[6];

    initial begin
        int c1, viol, rd0, n;
        tab[0] = '{"a5", 8'hA5, 10'b1101001010};
        tab[1] = '{"3c", 8'h3C, 10'b1001111000};
        tab[2] = '{"55", 8'h55, 10'b1010101010};
        tab[3] = '{"00", 8'h00, 10'b1000000000};
        tab[4] = '{"ff", 8'hFF, 10'b1111111110};
        tab[5] = '{"01", 8'h01, 10'b1000000010};

        bus.tx_en = 1'b0;
        refresh();
        repeat (3) tick();
        push(8'h11);
        bus.tx_en = 1'b1;
        #1;
        check("reset tx", {31'd0, bus.tx}, 32'd1);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset rd masked", {31'd0, bus.fifo_rd}, 32'd0);
        bus.tx_en = 1'b0;
        q.delete();
        refresh();
        tick();
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            push(tab[i].data);
            bus.tx_en = 1'b1;
            #1;
            run_frame(tab[i].name, tab[i].bits, -1);
            bus.tx_en = 1'b0;
            repeat (3) tick();
        end

        // Back-to-back frames
        push(8'h01);
        push(8'hFF);
        bus.tx_en = 1'b1;
        #1;
        wait_rd("b2b first", 5);
        c1 = cyc;
        tick();
        wait_rd("b2b second", 60);
        check("b2b period", cyc - c1, FRAME + 1);
        run_frame("b2b ff", 10'b1111111110, -1);
        check("b2b fifo empty", {31'd0, bus.fifo_empty}, 32'd1);
        bus.tx_en = 1'b0;
        tick();

        // Empty FIFO with tx_en high, then data present with tx_en low
        viol = 0;
        bus.tx_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                bus.tx_en = 1'b0;
                push(8'h77);
                #1;
            end
            tick();
            if (bus.fifo_rd || bus.busy || !bus.tx) viol++;
        end
        check("empty/disabled quiet", viol, 0);
        q.delete();
        refresh();
        tick();

        // tx_en dropped mid-frame
        push(8'h3C);
        push(8'h99);
        bus.tx_en = 1'b1;
        #1;
        run_frame("drop 3c", 10'b1001111000, 10);
        rd0 = rd_total;
        repeat (60) tick();
        check("drop no further rd", rd_total - rd0, 0);
        check("drop word kept", q.size(), 1);
        q.delete();
        refresh();
        tick();

        // Reset mid-frame
        push(8'h55);
        bus.tx_en = 1'b1;
        #1;
        wait_rd("rst 55", 5);
        repeat (17) tick();
        check("rst busy before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst tx immediate", {31'd0, bus.tx}, 32'd1);
        check("rst busy immediate", {31'd0, bus.busy}, 32'd0);
        bus.tx_en = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        check("rst word lost", q.size(), 0);
        tick();
        push(8'hA5);
        bus.tx_en = 1'b1;
        #1;
        run_frame("post rst a5", 10'b1101001010, -1);
        bus.tx_en = 1'b0;
        tick();

        // Full-FIFO drain
        rd0 = rd_total;
        for (int k = 0; k < 16; k++) push(8'(k));
        bus.tx_en = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            logic [7:0] d;
            d = 8'(k);
            run_frame($sformatf("drain %0d", k), {1'b1, d, 1'b0}, -1);
        end
        check("drain rd count", rd_total - rd0, 16);
        check("drain fifo empty", {31'd0, bus.fifo_empty}, 32'd1);
        bus.tx_en = 1'b0;
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0 && q.size() < 16) push(8'($urandom));
            if ($urandom_range(19) == 0) bus.tx_en = ~bus.tx_en;
            if ($urandom_range(499) == 0) reset = 1'b1;
            else reset = 1'b0;
            #1;
            tick();
        end
        reset = 1'b0;
        bus.tx_en = 1'b1;
        n = 0;
        while ((q.size() != 0 || bus.busy) && n < 16 * int'(FRAME + 1) + 100) begin
            tick();
            n++;
        end
        check("random drained", {31'd0, bus.fifo_empty}, 32'd1);
        check("random idle", {31'd0, bus.busy}, 32'd0);
        bus.tx_en = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
